// File: rtl/vram_access_responder.sv
// vram_access_responder: queues VDP VRAM slot accesses and replays them over a
// level-handshake backing-memory port, returning read data to the VDP side.
// Optional feature macro: VRAM_OVERFLOW_STATUS_EN (sticky overflow flag).

`ifndef MEMORY_WIDTH_8
`define MEMORY_WIDTH_8  2'b00
`endif
`ifndef MEMORY_WIDTH_16
`define MEMORY_WIDTH_16 2'b01
`endif
`ifndef MEMORY_WIDTH_32
`define MEMORY_WIDTH_32 2'b10
`endif

module vram_access_responder #(
   parameter int FIFO_DEPTH = 2
) (
   input  logic        CLK21M,
   input  logic        RESET,
   input  logic [1:0]  DOTSTATE,
   input  logic [17:0] IRAMADR,
   input  logic        PRAMWE_N,
   input  logic [1:0]  PRAM_WR_SIZE,
   input  logic [7:0]  PRAMDBO_8,
   input  logic [15:0] PRAMDBO_16,
   input  logic [31:0] PRAMDBO_32,
   output logic        mem_req,
   input  logic        mem_ack,
   output logic [15:0] mem_addr,
   output logic        mem_wr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic [31:0] PRAMDBI_32,
   output logic [7:0]  PRAMDBI_8,
   output logic        rd_valid,
   output logic        busy,
   output logic        overflow
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   // Write lanes and byte enables are resolved at push time, so the queue
   // holds exactly what goes onto the memory bus.
   typedef struct packed {
      logic [17:0] addr;
      logic        wr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } entry_t;

   entry_t             fifo_q [FIFO_DEPTH];
   entry_t             fifo_d [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [1:0]         state_q, state_d;
   logic               mem_req_q, mem_req_d;
   logic [15:0]        mem_addr_q, mem_addr_d;
   logic               mem_wr_q, mem_wr_d;
   logic [3:0]         mem_be_q, mem_be_d;
   logic [31:0]        mem_wdata_q, mem_wdata_d;
   logic [31:0]        pramdbi_32_q, pramdbi_32_d;
   logic [7:0]         pramdbi_8_q, pramdbi_8_d;
   logic               rd_valid_q, rd_valid_d;

   entry_t             new_entry;
   entry_t             head;
   logic               push;
   logic               pop;
   logic               full;
   logic               push_ok;
   logic               drop;

   // Format the incoming slot into a bus-ready entry; unknown width codes act as bytes.
   always_comb begin
      new_entry       = '0;
      new_entry.addr  = IRAMADR;
      new_entry.wr    = ~PRAMWE_N;
      if (!PRAMWE_N) begin
         case (PRAM_WR_SIZE)
            `MEMORY_WIDTH_16: begin
               new_entry.be    = IRAMADR[1] ? 4'b1100 : 4'b0011;
               new_entry.wdata = {2{PRAMDBO_16}};
            end
            `MEMORY_WIDTH_32: begin
               new_entry.be    = 4'b1111;
               new_entry.wdata = PRAMDBO_32;
            end
            default: begin
               new_entry.be    = 4'b0001 << IRAMADR[1:0];
               new_entry.wdata = {4{PRAMDBO_8}};
            end
         endcase
      end
   end

   // Queue bookkeeping: a push into a full queue only survives if the head leaves this cycle.
   always_comb begin
      head     = fifo_q[rd_ptr_q];
      push     = (DOTSTATE == 2'b00) && !RESET;
      pop      = (state_q == ST_ISSUE) && mem_ack;
      full     = (count_q == CNT_W'(FIFO_DEPTH));
      push_ok  = push && (!full || pop);
      drop     = push && !push_ok;
      fifo_d   = fifo_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         fifo_d[wr_ptr_q] = new_entry;
         wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      if (push_ok && !pop) begin
         count_d = count_q + 1'b1;
      end else if (!push_ok && pop) begin
         count_d = count_q - 1'b1;
      end
   end

   // Handshake sequencer: load the bus from the head, hold until ack, then rest one cycle.
   always_comb begin
      state_d      = state_q;
      mem_req_d    = mem_req_q;
      mem_addr_d   = mem_addr_q;
      mem_wr_d     = mem_wr_q;
      mem_be_d     = mem_be_q;
      mem_wdata_d  = mem_wdata_q;
      pramdbi_32_d = pramdbi_32_q;
      pramdbi_8_d  = pramdbi_8_q;
      rd_valid_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (count_q != '0) begin
               state_d     = ST_ISSUE;
               mem_req_d   = 1'b1;
               mem_addr_d  = head.addr[17:2];
               mem_wr_d    = head.wr;
               mem_be_d    = head.be;
               mem_wdata_d = head.wdata;
            end
         end
         ST_ISSUE: begin
            if (mem_ack) begin
               state_d   = ST_DONE;
               mem_req_d = 1'b0;
               if (!head.wr) begin
                  pramdbi_32_d = mem_rdata;
                  pramdbi_8_d  = mem_rdata[{head.addr[1:0], 3'b000} +: 8];
                  rd_valid_d   = 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Control and output registers; reset abandons any transaction in flight.
   always_ff @(posedge CLK21M) begin
      if (RESET) begin
         state_q      <= ST_IDLE;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         mem_req_q    <= 1'b0;
         mem_addr_q   <= '0;
         mem_wr_q     <= 1'b0;
         mem_be_q     <= '0;
         mem_wdata_q  <= '0;
         pramdbi_32_q <= '0;
         pramdbi_8_q  <= '0;
         rd_valid_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         mem_req_q    <= mem_req_d;
         mem_addr_q   <= mem_addr_d;
         mem_wr_q     <= mem_wr_d;
         mem_be_q     <= mem_be_d;
         mem_wdata_q  <= mem_wdata_d;
         pramdbi_32_q <= pramdbi_32_d;
         pramdbi_8_q  <= pramdbi_8_d;
         rd_valid_q   <= rd_valid_d;
      end
   end

   // Queue storage needs no reset; the pointers alone define what is valid.
   always_ff @(posedge CLK21M) begin
      fifo_q <= fifo_d;
   end

`ifdef VRAM_OVERFLOW_STATUS_EN
   logic overflow_q, overflow_d;

   // Sticky record of any dropped slot, cleared only by reset.
   always_comb begin
      overflow_d = overflow_q | drop;
   end

   // Overflow flag register.
   always_ff @(posedge CLK21M) begin
      if (RESET) begin
         overflow_q <= 1'b0;
      end else begin
         overflow_q <= overflow_d;
      end
   end

   assign overflow = overflow_q;
`else
   logic unused_drop;
   assign unused_drop = drop;
   assign overflow    = 1'b0;
`endif

   assign mem_req    = mem_req_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wr     = mem_wr_q;
   assign mem_be     = mem_be_q;
   assign mem_wdata  = mem_wdata_q;
   assign PRAMDBI_32 = pramdbi_32_q;
   assign PRAMDBI_8  = pramdbi_8_q;
   assign rd_valid   = rd_valid_q;
   assign busy       = (state_q != ST_IDLE) || (count_q != '0);

endmodule

// File: doc/vram_access_responder.md
VRAM_ACCESS_RESPONDER -- requirements
Module: vram_access_responder

Interface
REQ-001 Parameter FIFO_DEPTH, default 2, SHALL set the request queue depth; legal values are 2, 4 and 8.
REQ-002 CLK21M  in  1  SHALL be the only clock; all state updates on its rising edge.
REQ-003 RESET  in  1  SHALL be a synchronous, active-high reset.
REQ-004 DOTSTATE  in  2  SHALL be the dot phase; a slot is sampled in each cycle where DOTSTATE==2'b00.
REQ-005 IRAMADR  in  18  SHALL be the byte address of the slot's access.
REQ-006 PRAMWE_N  in  1  SHALL select the access type: 0 = write, 1 = read.
REQ-007 PRAM_WR_SIZE  in  2  SHALL give the write width as `MEMORY_WIDTH_8, `MEMORY_WIDTH_16 or `MEMORY_WIDTH_32.
REQ-008 PRAMDBO_8 / PRAMDBO_16 / PRAMDBO_32  in  8/16/32  SHALL carry the write data for each width.
REQ-009 mem_req  out  1, mem_ack  in  1  SHALL form the backing-memory handshake; mem_req is level and held until mem_ack.
REQ-010 mem_addr  out  16  SHALL carry the word address, IRAMADR[17:2].
REQ-011 mem_wr  out  1, mem_be  out  4, mem_wdata  out  32  SHALL carry the write strobe, byte enables and write data.
REQ-012 mem_rdata  in  32  SHALL be the read word, valid in the cycle mem_ack is high for a read.
REQ-013 PRAMDBI_32  out  32 and PRAMDBI_8  out  8  SHALL return read data.
REQ-014 rd_valid  out  1  SHALL pulse for one cycle when read data updates.
REQ-015 busy  out  1  SHALL indicate that the FIFO is non-empty or a transaction is in flight.
REQ-016 overflow  out  1  SHALL be a sticky dropped-request flag.

Function
REQ-017 Each sampled slot SHALL push {addr, we, size, data} into the FIFO; pushes are unconditional, so draw reads are pushed too.
REQ-018 If a push meets a full FIFO with no pop in the same cycle, the new request SHALL be dropped and overflow set; a push and pop in the same cycle on a full FIFO SHALL both succeed.
REQ-019 The FSM SHALL have states IDLE, ISSUE and DONE.
REQ-020 IDLE SHALL go to ISSUE when the FIFO is non-empty, with mem_req high from the next edge.
REQ-021 ISSUE SHALL hold mem_req and the head fields stable until mem_ack is high.
REQ-022 On ISSUE with mem_ack high: pop the head, drop mem_req at the next edge, go to DONE.
REQ-023 DONE SHALL last one cycle, then return to IDLE.
REQ-024 Minimum latency SHALL be: push at edge T, mem_req high after edge T+1.
REQ-025 A write with `MEMORY_WIDTH_8 SHALL replicate the byte to all four lanes, with mem_be = 1<<IRAMADR[1:0].
REQ-026 A write with `MEMORY_WIDTH_16 SHALL replicate the half to both halves, with mem_be = IRAMADR[1] ? 4'b1100 : 4'b0011.
REQ-027 A write with `MEMORY_WIDTH_32 SHALL use mem_be = 4'b1111 and ignore IRAMADR[1:0].
REQ-028 The unused PRAM_WR_SIZE code SHALL be treated as `MEMORY_WIDTH_8.
REQ-029 For reads, mem_wr and mem_be SHALL be 0.
REQ-030 On a read acknowledge, PRAMDBI_32 SHALL take mem_rdata and PRAMDBI_8 SHALL take byte IRAMADR[1:0] of it, both registered with rd_valid high the next cycle; the outputs hold their value otherwise.
REQ-031 mem_ack SHALL be ignored outside ISSUE.
REQ-032 FIFO pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-033 RESET SHALL empty the FIFO, force the FSM to IDLE, and zero mem_req, mem_wr, mem_be, mem_addr, mem_wdata, PRAMDBI_32, PRAMDBI_8, rd_valid, busy and overflow at the next edge.
REQ-034 RESET during ISSUE SHALL abandon the transaction; a late mem_ack SHALL be ignored.
REQ-035 No sample SHALL occur in a cycle where RESET is high.

Configuration
REQ-036 With VRAM_OVERFLOW_STATUS_EN defined, overflow SHALL behave per REQ-018 and clear only on RESET.
REQ-037 Without VRAM_OVERFLOW_STATUS_EN, overflow SHALL be tied to 0 and dropping per REQ-018 SHALL still occur.

Verification
REQ-038 Write 8-bit 0x5A at IRAMADR 0x00006, ack in 1 cycle -> mem_addr 0x0001, mem_be 4'b0100, mem_wdata 0x5A5A5A5A, mem_wr 1.
REQ-039 Read at 0x00103, mem_rdata 0x11223344 -> PRAMDBI_32 0x11223344, PRAMDBI_8 0x11, single-cycle rd_valid.
REQ-040 mem_ack held low for 12 cycles with FIFO_DEPTH 2 -> third slot dropped, overflow 1 (macro on) / 0 (macro off), first two requests completed in order.
REQ-041 16-bit write 0xBEEF at 0x00002 -> mem_be 4'b1100, mem_wdata 0xBEEFBEEF; 32-bit write at 0x00003 -> mem_be 4'b1111.
REQ-042 RESET asserted during ISSUE, then mem_ack pulsed -> mem_req 0, busy 0, no rd_valid, FIFO empty.
